// File: rtl/sample_cond_pkg.sv
// Shared constants and AGC decision helper for the sample conditioner.
package sample_cond_pkg;

    localparam int unsigned SAMPLE_WIDTH_DEFAULT = 12;
    localparam int unsigned DATA_W_DEFAULT       = 8;
    localparam int unsigned OFFSET               = 128;
    localparam int unsigned AGC_LOW_THRESH       = 32;
    localparam int unsigned GAIN_W               = 3;
    localparam int unsigned OVERRUN_W            = 8;

    typedef enum logic [1:0] {
        AGC_HOLD = 2'd0,
        AGC_UP   = 2'd1,
        AGC_DOWN = 2'd2
    } agc_step_e;

    // Clipping in the window wins over a quiet window.
    function automatic agc_step_e agc_decide(
        input logic clipped,
        input logic below_low,
        input logic at_min,
        input logic at_max
    );
        if (clipped && !at_min) begin
            return AGC_DOWN;
        end else if (below_low && !at_max) begin
            return AGC_UP;
        end
        return AGC_HOLD;
    endfunction

endpackage

// File: rtl/sample_conditioner_dc_blocker.sv
// DC tracker: leaky integrator seeded by the first sample; emits x - dc one clock later.
module dc_blocker
    import sample_cond_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
    parameter int unsigned DC_SHIFT     = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SAMPLE_WIDTH-1:0]        i_x,
    input  logic                           i_valid,
    output logic signed [SAMPLE_WIDTH:0]   o_centered,
    output logic                           o_valid
);

    localparam int unsigned AW = SAMPLE_WIDTH + DC_SHIFT;

    logic [AW-1:0]                 r_acc;
    logic                          r_seeded;
    logic [SAMPLE_WIDTH-1:0]       w_dc;
    logic [AW-1:0]                 w_acc_next;
    logic signed [SAMPLE_WIDTH:0]  w_diff;

    always_comb begin
        w_dc       = SAMPLE_WIDTH'(r_acc >> DC_SHIFT);
        w_acc_next = r_acc - AW'(w_dc) + AW'(i_x);
        w_diff     = $signed({1'b0, i_x}) - $signed({1'b0, w_dc});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc      <= '0;
            r_seeded   <= 1'b0;
            o_centered <= '0;
            o_valid    <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                if (r_seeded) begin
                    r_acc      <= w_acc_next;
                    o_centered <= w_diff;
                end else begin
                    r_acc      <= AW'(i_x) << DC_SHIFT;
                    r_seeded   <= 1'b1;
                    o_centered <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/sample_conditioner.sv
// ADC sample conditioner: DC removal, shift gain, saturation, one-entry output buffer.
// Define SAMPLE_CONDITIONER_AGC_EN to let the gain adapt once per AGC window.
module sample_conditioner
    import sample_cond_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
    parameter int unsigned DATA_W       = DATA_W_DEFAULT,
    parameter int unsigned DC_SHIFT     = 6,
    parameter int unsigned GAIN_INIT    = 2,
    parameter int unsigned GAIN_MAX     = 4,
    parameter int unsigned AGC_WINDOW   = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SAMPLE_WIDTH-1:0]  adc_data,
    input  logic                     adc_valid,
    output logic [DATA_W-1:0]        out_sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [GAIN_W-1:0]        gain,
    output logic                     clip,
    output logic [OVERRUN_W-1:0]     overrun,
    output logic [DATA_W-1:0]        level
);

    localparam int unsigned CW    = SAMPLE_WIDTH + 1;
    localparam int unsigned SW    = CW + GAIN_MAX;
    localparam int unsigned MW    = DATA_W - 1;
    localparam int unsigned WIN_W = (AGC_WINDOW > 1) ? $clog2(AGC_WINDOW) : 1;
    localparam logic signed [SW-1:0] SAT_HI   = SW'((1 << MW) - 1);
    localparam logic signed [SW-1:0] SAT_LO   = SW'(-(1 << MW));
    localparam logic [MW-1:0]        MAG_MAX  = MW'((1 << MW) - 1);
    localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(AGC_WINDOW - 1);

    logic [SAMPLE_WIDTH-1:0]  r_s1_x;
    logic                     r_s1_valid;
    logic signed [CW-1:0]     w_centered;
    logic                     w_s2_valid;
    logic [GAIN_W-1:0]        w_gain;
    logic signed [SW-1:0]     w_scaled;
    logic signed [SW-1:0]     w_abs;
    logic                     w_sat_hi;
    logic                     w_sat_lo;
    logic                     w_clip;
    logic [DATA_W-1:0]        w_sat;
    logic [DATA_W-1:0]        w_out;
    logic [MW-1:0]            w_mag;
    logic [MW-1:0]            w_peak_next;
    logic                     w_win_last;
    logic                     w_load;

    logic [DATA_W-1:0]        r_out_sample;
    logic                     r_out_valid;
    logic                     r_clip;
    logic [OVERRUN_W-1:0]     r_overrun;
    logic [DATA_W-1:0]        r_level;
    logic [MW-1:0]            r_peak;
    logic [WIN_W-1:0]         r_win_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_x     <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= adc_valid;
            if (adc_valid) begin
                r_s1_x <= adc_data;
            end
        end
    end

    dc_blocker #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .DC_SHIFT     (DC_SHIFT)
    ) u_dc_blocker (
        .clk        (clk),
        .reset      (reset),
        .i_x        (r_s1_x),
        .i_valid    (r_s1_valid),
        .o_centered (w_centered),
        .o_valid    (w_s2_valid)
    );

    // Gain, saturation and offset; the peak magnitude is taken before saturation.
    always_comb begin
        w_scaled    = SW'(w_centered) <<< w_gain;
        w_sat_hi    = w_scaled > SAT_HI;
        w_sat_lo    = w_scaled < SAT_LO;
        w_clip      = w_sat_hi | w_sat_lo;
        w_sat       = w_sat_hi ? DATA_W'(SAT_HI) :
                      w_sat_lo ? DATA_W'(SAT_LO) : w_scaled[DATA_W-1:0];
        w_out       = w_sat + DATA_W'(OFFSET);
        w_abs       = w_scaled[SW-1] ? -w_scaled : w_scaled;
        w_mag       = (w_abs > SAT_HI) ? MAG_MAX : w_abs[MW-1:0];
        w_peak_next = (w_mag > r_peak) ? w_mag : r_peak;
        w_win_last  = r_win_cnt == WIN_LAST;
        w_load      = w_s2_valid && (!r_out_valid || out_ready);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_sample <= DATA_W'(OFFSET);
            r_out_valid  <= 1'b0;
            r_clip       <= 1'b0;
            r_overrun    <= '0;
            r_level      <= '0;
            r_peak       <= '0;
            r_win_cnt    <= '0;
        end else begin
            r_clip <= w_load && w_clip;
            if (w_load) begin
                r_out_sample <= w_out;
                r_out_valid  <= 1'b1;
            end else if (out_ready) begin
                r_out_valid  <= 1'b0;
            end
            // A result that finds the buffer still held is lost.
            if (w_s2_valid && !w_load && (r_overrun != '1)) begin
                r_overrun <= r_overrun + 1'b1;
            end
            if (w_s2_valid) begin
                r_win_cnt <= r_win_cnt + 1'b1;
                if (w_win_last) begin
                    r_level <= DATA_W'(w_peak_next);
                    r_peak  <= '0;
                end else begin
                    r_peak  <= w_peak_next;
                end
            end
        end
    end

`ifdef SAMPLE_CONDITIONER_AGC_EN
    localparam logic [MW-1:0] LOW_TH = MW'(AGC_LOW_THRESH);

    logic [GAIN_W-1:0] r_gain;
    logic              r_win_clip;
    agc_step_e         w_step;

    always_comb begin
        w_step = agc_decide(r_win_clip | w_clip, w_peak_next < LOW_TH,
                            r_gain == '0, r_gain >= GAIN_W'(GAIN_MAX));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gain     <= GAIN_W'(GAIN_INIT);
            r_win_clip <= 1'b0;
        end else if (w_s2_valid) begin
            if (w_win_last) begin
                r_win_clip <= 1'b0;
                if (w_step == AGC_UP) begin
                    r_gain <= r_gain + 1'b1;
                end else if (w_step == AGC_DOWN) begin
                    r_gain <= r_gain - 1'b1;
                end
            end else if (w_clip) begin
                r_win_clip <= 1'b1;
            end
        end
    end

    assign w_gain = r_gain;
`else
    assign w_gain = GAIN_W'(GAIN_INIT);
`endif

    assign out_sample = r_out_sample;
    assign out_valid  = r_out_valid;
    assign clip       = r_clip;
    assign overrun    = r_overrun;
    assign level      = r_level;
    assign gain       = w_gain;

endmodule

// File: tb/tb_sample_conditioner.sv
// Bench for sample_conditioner: directed vector table, handshake/reset sequences,
// random stimulus against a per-sample arithmetic model (AGC part under SAMPLE_CONDITIONER_AGC_EN).
module tb_sample_conditioner;

    localparam int WIN  = 16;
    localparam int GMAX = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        adc_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [11:0] adc_data  = '0;

    logic [7:0] os0, os1, or0, or1, lv0, lv1;
    logic [2:0] gn0, gn1;
    logic       ov0, ov1, cl0, cl1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sample_conditioner #(.GAIN_INIT(0), .GAIN_MAX(GMAX), .AGC_WINDOW(WIN)) u_dut0 (
        .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
        .out_sample(os0), .out_valid(ov0), .out_ready(out_ready),
        .gain(gn0), .clip(cl0), .overrun(or0), .level(lv0));

    sample_conditioner #(.GAIN_INIT(2), .GAIN_MAX(GMAX), .AGC_WINDOW(WIN)) u_dut1 (
        .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
        .out_sample(os1), .out_valid(ov1), .out_ready(out_ready),
        .gain(gn1), .clip(cl1), .overrun(or1), .level(lv1));

    // Reference model state, one set per DUT instance.
    int m_acc[2], m_gain[2], m_peak[2], m_cnt[2], m_level[2];
    bit m_seeded[2], m_clipw[2];
    int gain_init[2] = '{0, 2};

    typedef struct { bit rst; int x; int e0; int c0; int e1; int c1; } vec_t;
    typedef struct { int due; int x; } pend_t;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_seeded[k] = 0; m_gain[k] = gain_init[k];
            m_peak[k] = 0; m_cnt[k] = 0; m_level[k] = 0; m_clipw[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input int x, output int eo, output int ec);
        int c, s, sat, mag;
        if (!m_seeded[k]) begin
            m_acc[k] = x * 64; m_seeded[k] = 1; c = 0;
        end else begin
            c = x - m_acc[k] / 64;
            m_acc[k] = m_acc[k] + c;
        end
        s   = c * (1 << m_gain[k]);
        sat = (s > 127) ? 127 : ((s < -128) ? -128 : s);
        ec  = (s != sat) ? 1 : 0;
        eo  = sat + 128;
        mag = (s < 0) ? -s : s;
        if (mag > 127) mag = 127;
        if (mag > m_peak[k]) m_peak[k] = mag;
        if (ec != 0) m_clipw[k] = 1;
        m_cnt[k]++;
        if (m_cnt[k] == WIN) begin
            m_level[k] = m_peak[k];
`ifdef SAMPLE_CONDITIONER_AGC_EN
            if (m_clipw[k] && m_gain[k] > 0) m_gain[k]--;
            else if (m_peak[k] < 32 && m_gain[k] < GMAX) m_gain[k]++;
`endif
            m_peak[k] = 0; m_clipw[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic check_outs(input string tag, input bit ev, input int e0, input int c0,
                              input int e1, input int c1);
        chk({tag, " valid0"}, ov0, ev);
        chk({tag, " valid1"}, ov1, ev);
        if (ev) begin
            chk({tag, " sample0"}, os0, e0);
            chk({tag, " sample1"}, os1, e1);
        end
        chk({tag, " clip0"}, cl0, c0);
        chk({tag, " clip1"}, cl1, c1);
        chk({tag, " gain0"}, gn0, m_gain[0]);
        chk({tag, " gain1"}, gn1, m_gain[1]);
        chk({tag, " level0"}, lv0, m_level[0]);
        chk({tag, " level1"}, lv1, m_level[1]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; adc_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse(input int x);
        @(negedge clk);
        adc_data = 12'(x); adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    // One strobe; output must appear exactly at the third edge and clip must last one cycle.
    task automatic send(input int x, input int gap, output int a0, output int a1,
                        output int k0, output int k1);
        int e0, c0, e1, c1;
        pulse(x);
        @(negedge clk);
        check_outs("pre", 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        model_step(0, x, e0, c0);
        model_step(1, x, e1, c1);
        check_outs("load", 1'b1, e0, c0, e1, c1);
        a0 = os0; a1 = os1; k0 = cl0; k1 = cl1;
        @(negedge clk);
        check_outs("post", 1'b0, 0, 0, 0, 0);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        vec_t  tab[11];
        pend_t q[$];
        pend_t p;
        int a0, a1, k0, k1, e0, c0, e1, c1, x, base;

        tab = '{
            '{1'b1, 2048, 128, 0, 128, 0}, '{1'b0, 2048, 128, 0, 128, 0},
            '{1'b0, 2048, 128, 0, 128, 0}, '{1'b0, 2112, 192, 0, 255, 1},
            '{1'b0, 2112, 191, 0, 255, 1}, '{1'b0, 2112, 191, 0, 255, 1},
            '{1'b0, 2112, 190, 0, 255, 1},
            '{1'b1, 2048, 128, 0, 128, 0}, '{1'b0, 2048, 128, 0, 128, 0},
            '{1'b0, 2448, 255, 1, 255, 1}, '{1'b0, 1648,   0, 1,   0, 1}
        };

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst sample0", os0, 128); chk("rst sample1", os1, 128);
        chk("rst valid0", ov0, 0);    chk("rst clip0", cl0, 0);
        chk("rst overrun0", or0, 0);  chk("rst level0", lv0, 0);
        chk("rst gain0", gn0, 0);     chk("rst gain1", gn1, 2);
        reset = 1'b0;
        model_reset();

        // Constant mid-scale input stays at the offset
        for (int i = 0; i < 8; i++) begin
            send(2048, 10, a0, a1, k0, k1);
            chk("const out0", a0, 128); chk("const out1", a1, 128);
            chk("const clip0", k0, 0);  chk("const clip1", k1, 0);
        end

        // Step response and saturation vectors
        for (int i = 0; i < 11; i++) begin
            if (tab[i].rst) do_reset();
            send(tab[i].x, 2, a0, a1, k0, k1);
            chk($sformatf("vec%0d out0", i), a0, tab[i].e0);
            chk($sformatf("vec%0d clip0", i), k0, tab[i].c0);
            chk($sformatf("vec%0d out1", i), a1, tab[i].e1);
            chk($sformatf("vec%0d clip1", i), k1, tab[i].c1);
        end

        // Back-pressure: held sample, overrun, then release
        do_reset();
        send(2048, 2, a0, a1, k0, k1);
        out_ready = 1'b0;
        pulse(2112);
        repeat (2) @(negedge clk);
        chk("hold first valid", ov0, 1); chk("hold first sample0", os0, 192);
        chk("hold first sample1", os1, 255); chk("hold overrun0", or0, 0);
        pulse(2200);
        repeat (2) @(negedge clk);
        chk("drop valid", ov0, 1); chk("drop sample0", os0, 192);
        chk("drop overrun0", or0, 1); chk("drop overrun1", or1, 1);
        repeat (3) @(negedge clk);
        chk("held sample0", os0, 192); chk("held valid", ov0, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("release valid0", ov0, 0); chk("release valid1", ov1, 0);

        // Asynchronous reset with a held output and a sample in flight
        out_ready = 1'b0;
        pulse(2300);
        repeat (2) @(negedge clk);
        chk("pre-reset valid", ov0, 1);
        pulse(2400);
        #2 reset = 1'b1;
        #1;
        chk("async sample0", os0, 128); chk("async sample1", os1, 128);
        chk("async valid0", ov0, 0);    chk("async valid1", ov1, 0);
        chk("async clip0", cl0, 0);     chk("async overrun0", or0, 0);
        chk("async overrun1", or1, 0);  chk("async level0", lv0, 0);
        chk("async gain0", gn0, 0);     chk("async gain1", gn1, 2);
        repeat (2) @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flushed valid0", ov0, 0);
        end
        send(3000, 2, a0, a1, k0, k1);
        chk("reseed out0", a0, 128); chk("reseed out1", a1, 128);

        // Random traffic against the model
        do_reset();
        base = 2048;
        for (int i = 0; i < 3006; i++) begin
            @(negedge clk);
            if (q.size() > 0 && q[0].due == cyc) begin
                p = q.pop_front();
                model_step(0, p.x, e0, c0);
                model_step(1, p.x, e1, c1);
                check_outs("rnd", 1'b1, e0, c0, e1, c1);
            end else begin
                check_outs("rnd", 1'b0, 0, 0, 0, 0);
            end
            if (i % 500 == 0) base = int'($urandom_range(1000, 3000));
            if (i < 3000 && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 15) == 0) x = int'($urandom_range(0, 4095));
                else x = base + int'($urandom_range(0, 80)) - 40;
                adc_data = 12'(x); adc_valid = 1'b1;
                q.push_back('{cyc + 3, x});
            end else begin
                adc_valid = 1'b0;
            end
        end
        chk("rnd queue drained", q.size(), 0);

`ifdef SAMPLE_CONDITIONER_AGC_EN
        // Quiet input raises gain to the cap; clipping input lowers it one step per window
        do_reset();
        send(2048, 1, a0, a1, k0, k1);
        for (int i = 1; i < 64; i++) begin
            send((i % 2 != 0) ? 2050 : 2046, 1, a0, a1, k0, k1);
            if (i == 15) begin chk("agc w1 gain1", gn1, 3); chk("agc w1 gain0", gn0, 1); end
            if (i == 31) begin chk("agc w2 gain1", gn1, 4); chk("agc w2 gain0", gn0, 2); end
            if (i == 63) begin chk("agc cap gain1", gn1, 4); chk("agc cap gain0", gn0, 4); end
        end
        for (int j = 0; j < 80; j++) begin
            send((j % 2 != 0) ? 1448 : 2648, 1, a0, a1, k0, k1);
            if ((j + 1) % 16 == 0) begin
                chk($sformatf("agc clip w%0d gain1", (j + 1) / 16), gn1,
                    ((4 - (j + 1) / 16) > 0) ? (4 - (j + 1) / 16) : 0);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
